// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Converts a 14-bit binary value to four BCD digits with a sequential
//   double-dabble engine and time-multiplexes them onto a single digit bus.
//
// Parameters
//   REFRESH_DIV : clk cycles spent on each digit slot (2 .. 2^20)
//   BLANK_LZ    : 1 = blank leading zeros (units digit is never blanked)
//
// Ports
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   value : unsigned number to display
//   load  : start a conversion of value (ignored while busy)
//   busy  : conversion in progress (14 cycles)
//   done  : one-cycle pulse when the new digits become visible
//   en    : digit slot select, 0 = thousands .. 3 = units
//   bcd   : digit for the selected slot, 4'hF = blank
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [1:0]  en,
  output logic [3:0]  bcd
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [3:0] LAST_STEP = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] presc;
  logic          tick;
  logic [13:0]   bin;
  logic [15:0]   acc;
  logic [15:0]   acc_adj;
  logic [15:0]   acc_shift;
  logic [3:0]    step;
  logic          ovf;
  logic [15:0]   disp;
  logic [15:0]   disp_new;
  logic          start;

  // Refresh prescaler and slot scan; runs regardless of conversion activity.
  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      en    <= '0;
    end else begin
      if (tick) begin
        presc <= '0;
        en    <= en + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. S_DONE accepts a new load just like S_IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_CONV;
      S_CONV:  if (step == LAST_STEP) state_d = S_DONE;
      S_DONE:  state_d = load ? S_CONV : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == S_CONV);
    done = (state_q == S_DONE);
  end

  assign start = load && (state_q != S_CONV);

  // Double-dabble step: add 3 to any digit >= 5, then shift in the next bit.
  always_comb begin
    acc_adj = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      acc_adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3
                                                   : acc[4*i +: 4];
    end
    acc_shift = {acc_adj[14:0], bin[13]};
  end

  // Digits committed on the final step, with overflow and leading-zero blanking.
  always_comb begin
    disp_new = acc_shift;
    if (ovf) begin
      disp_new = '1;
    end else if (BLANK_LZ) begin
      if (acc_shift[15:12] == 4'd0) begin
        disp_new[15:12] = 4'hF;
        if (acc_shift[11:8] == 4'd0) begin
          disp_new[11:8] = 4'hF;
          if (acc_shift[7:4] == 4'd0) disp_new[7:4] = 4'hF;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin  <= '0;
      acc  <= '0;
      step <= '0;
      ovf  <= 1'b0;
      disp <= '1;
    end else if (start) begin
      bin  <= value;
      acc  <= '0;
      step <= '0;
      ovf  <= (value > 14'd9999);
    end else if (state_q == S_CONV) begin
      bin  <= {bin[12:0], 1'b0};
      acc  <= acc_shift;
      step <= step + 4'd1;
      if (step == LAST_STEP) disp <= disp_new;
    end
  end

  // Slot mux: en=0 is the leftmost (thousands) digit.
  always_comb begin
    case (en)
      2'd0:    bcd = disp[15:12];
      2'd1:    bcd = disp[11:8];
      2'd2:    bcd = disp[7:4];
      default: bcd = disp[3:0];
    endcase
  end

endmodule
